// File: rtl/s2p_cond_pkg.sv
// Shared definitions for the 4-lane serial-to-parallel receiver: state
// encodings, default alignment comma and bit-counter width.
package s2p_cond_pkg;

    localparam int         CTR_W         = 3;
    localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/s2p_cond_shift.sv
// One lane of the receiver: 8-bit MSB-first shift register. The next word is
// the byte that would be completed by the bit currently on the serial input.
module shift_s2p_cond (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enb,
    input  logic       sin,
    output logic [7:0] sh,
    output logic [7:0] nw
);

    logic [7:0] sh_reg;

    assign nw = {sh_reg[6:0], sin};
    assign sh = sh_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_reg <= '0;
        end else if (enb) begin
            sh_reg <= nw;
        end
    end

endmodule

// File: rtl/s2p_cond.sv
// 4-lane serial-to-parallel receiver with comma alignment on lane 0.
// Optional build macro S2P_COMMA_STRIP_EN suppresses strobes on comma slots while locked.
module s2p_cond
    import s2p_cond_pkg::*;
#(
    parameter logic [7:0] COMMA       = COMMA_DEFAULT,
    parameter int         LOCK_COMMAS = 2
) (
    input  logic             IN_CLK_s2p,
    input  logic             IN_RESET_s2p,
    input  logic             IN_ENB_s2p,
    input  logic             IN_VALID_s2p,
    input  logic [3:0]       IN_LANE_s2p,
    output logic [7:0]       OUT_LANE3_s2p,
    output logic [7:0]       OUT_LANE2_s2p,
    output logic [7:0]       OUT_LANE1_s2p,
    output logic [7:0]       OUT_LANE0_s2p,
    output logic             OUT_VALID_s2p,
    output logic             OUT_LOCK_s2p,
    output logic [CTR_W-1:0] OUT_CTR_s2p
);

`ifdef S2P_COMMA_STRIP_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif

    localparam logic [CTR_W-1:0] CTR_LAST    = '1;
    localparam logic [2:0]       LOCK_TARGET = 3'(LOCK_COMMAS);

    logic [3:0][7:0]   sh_all;
    logic [3:0][7:0]   nw_all;
    logic              shift_en;
    logic              comma_hit;

    state_t            state_reg, state_next;
    logic [CTR_W-1:0]  ctr_reg, ctr_next;
    logic [2:0]        cnt_reg, cnt_next;
    logic [3:0][7:0]   lane_reg, lane_next;
    logic              valid_reg, valid_next;

    // Shifting happens only on enabled bits of a valid stream.
    assign shift_en  = IN_ENB_s2p & IN_VALID_s2p;
    assign comma_hit = (nw_all[0] == COMMA);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            shift_s2p_cond u_shift (
                .clk   (IN_CLK_s2p),
                .rst_n (IN_RESET_s2p),
                .enb   (shift_en),
                .sin   (IN_LANE_s2p[gi]),
                .sh    (sh_all[gi]),
                .nw    (nw_all[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        ctr_next   = ctr_reg;
        cnt_next   = cnt_reg;
        lane_next  = lane_reg;
        valid_next = 1'b0;
        if (!IN_VALID_s2p) begin
            state_next = ST_HUNT;
            ctr_next   = '0;
            cnt_next   = '0;
        end else if (IN_ENB_s2p) begin
            case (state_reg)
                ST_HUNT: begin
                    if (comma_hit) begin
                        ctr_next   = '0;
                        cnt_next   = 3'd1;
                        state_next = (LOCK_TARGET == 3'd1) ? ST_LOCKED : ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    ctr_next = ctr_reg + 1'b1;
                    if (ctr_reg == CTR_LAST) begin
                        if (comma_hit) begin
                            cnt_next = cnt_reg + 3'd1;
                            if ((cnt_reg + 3'd1) == LOCK_TARGET) begin
                                state_next = ST_LOCKED;
                            end
                        end else begin
                            // Misaligned comma: restart the search bit by bit.
                            state_next = ST_HUNT;
                            cnt_next   = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    ctr_next = ctr_reg + 1'b1;
                    if (ctr_reg == CTR_LAST && !(STRIP && comma_hit)) begin
                        lane_next  = nw_all;
                        valid_next = 1'b1;
                    end
                end
                default: state_next = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge IN_CLK_s2p) begin
        if (!IN_RESET_s2p) begin
            state_reg <= ST_HUNT;
            ctr_reg   <= '0;
            cnt_reg   <= '0;
            lane_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ctr_reg   <= ctr_next;
            cnt_reg   <= cnt_next;
            lane_reg  <= lane_next;
            valid_reg <= valid_next;
        end
    end

    assign OUT_LANE3_s2p = lane_reg[3];
    assign OUT_LANE2_s2p = lane_reg[2];
    assign OUT_LANE1_s2p = lane_reg[1];
    assign OUT_LANE0_s2p = lane_reg[0];
    assign OUT_VALID_s2p = valid_reg;
    assign OUT_LOCK_s2p  = (state_reg == ST_LOCKED);
    assign OUT_CTR_s2p   = ctr_reg;

endmodule

// File: tb/tb_s2p_cond.sv
// Self-checking bench for s2p_cond: directed test-plan sequences with literal
// expectations, then randomized serial traffic checked against a byte-level model.
`timescale 1ns/1ps
module tb_s2p_cond;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enb;
    logic       vld;
    logic [3:0] lanes;
    logic [7:0] out3, out2, out1, out0;
    logic       out_valid;
    logic       out_lock;
    logic [2:0] out_ctr;

    int n_checks = 0;
    int n_fail   = 0;
    int strobes  = 0;

    // Reference model: lane histories, alignment progress and delivered words.
    int         m_mode;      // 0 searching, 1 confirming, 2 locked
    int         m_bitpos;    // bits received since the last byte boundary, mod 8
    int         m_commas;
    logic [7:0] m_hist [4];
    logic [7:0] m_out  [4];
    int         m_valid;

`ifdef S2P_COMMA_STRIP_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif
    localparam int LOCK_N = 2;

    s2p_cond dut (
        .IN_CLK_s2p    (clk),
        .IN_RESET_s2p  (rst_n),
        .IN_ENB_s2p    (enb),
        .IN_VALID_s2p  (vld),
        .IN_LANE_s2p   (lanes),
        .OUT_LANE3_s2p (out3),
        .OUT_LANE2_s2p (out2),
        .OUT_LANE1_s2p (out1),
        .OUT_LANE0_s2p (out0),
        .OUT_VALID_s2p (out_valid),
        .OUT_LOCK_s2p  (out_lock),
        .OUT_CTR_s2p   (out_ctr)
    );

    always #250 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic e, input logic v, input logic [3:0] l);
        logic [7:0] word [4];
        bit boundary;
        if (!r) begin
            m_mode = 0; m_bitpos = 0; m_commas = 0; m_valid = 0;
            for (int i = 0; i < 4; i++) begin
                m_hist[i] = 8'h00;
                m_out[i]  = 8'h00;
            end
        end else if (!v) begin
            m_mode = 0; m_bitpos = 0; m_commas = 0; m_valid = 0;
        end else if (!e) begin
            m_valid = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                word[i]   = 8'((int'(m_hist[i]) * 2 + int'(l[i])) % 256);
                m_hist[i] = word[i];
            end
            m_valid  = 0;
            boundary = (m_bitpos == 7);
            if (m_mode == 0) begin
                if (word[0] == 8'hBC) begin
                    m_bitpos = 0;
                    m_commas = 1;
                    m_mode   = (LOCK_N == 1) ? 2 : 1;
                end
            end else begin
                m_bitpos = (m_bitpos + 1) % 8;
                if (boundary && m_mode == 1) begin
                    if (word[0] == 8'hBC) begin
                        m_commas++;
                        if (m_commas == LOCK_N) m_mode = 2;
                    end else begin
                        m_mode = 0;
                        m_commas = 0;
                    end
                end else if (boundary && m_mode == 2) begin
                    if (!(STRIP && word[0] == 8'hBC)) begin
                        for (int i = 0; i < 4; i++) m_out[i] = word[i];
                        m_valid = 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_model();
        chk("lane3", int'(out3), int'(m_out[3]));
        chk("lane2", int'(out2), int'(m_out[2]));
        chk("lane1", int'(out1), int'(m_out[1]));
        chk("lane0", int'(out0), int'(m_out[0]));
        chk("valid", int'(out_valid), m_valid);
        chk("lock",  int'(out_lock), (m_mode == 2) ? 1 : 0);
        chk("ctr",   int'(out_ctr), m_bitpos);
    endtask

    // One clock: drive at the falling edge, model at the rising edge, compare at the next fall.
    task automatic cycle(input logic r, input logic e, input logic v, input logic [3:0] l);
        rst_n = r; enb = e; vld = v; lanes = l;
        @(posedge clk);
        model_update(r, e, v, l);
        @(negedge clk);
        compare_model();
        if (out_valid) strobes++;
    endtask

    task automatic send_bits(input logic [7:0] b3, input logic [7:0] b2,
                             input logic [7:0] b1, input logic [7:0] b0,
                             input int first, input int last);
        for (int k = first; k >= last; k--) begin
            cycle(1'b1, 1'b1, 1'b1, {b3[k], b2[k], b1[k], b0[k]});
        end
    endtask

    task automatic send_byte(input logic [7:0] b3, input logic [7:0] b2,
                             input logic [7:0] b1, input logic [7:0] b0);
        send_bits(b3, b2, b1, b0, 7, 0);
    endtask

    task automatic lock_up();
        send_byte(8'($urandom), 8'($urandom), 8'($urandom), 8'hBC);
        send_byte(8'($urandom), 8'($urandom), 8'($urandom), 8'hBC);
    endtask

    initial begin
        int s0;
        int tgt;
        logic [7:0] rb [4];
        rst_n = 1'b0; enb = 1'b1; vld = 1'b1; lanes = 4'h0;
        @(negedge clk);

        // Reset with random lane activity.
        cycle(1'b0, 1'b1, 1'b1, 4'($urandom));
        cycle(1'b0, 1'b1, 1'b1, 4'($urandom));
        chk("rst_lane0", int'(out0), 0);
        chk("rst_lane3", int'(out3), 0);
        chk("rst_lock", int'(out_lock), 0);
        chk("rst_ctr", int'(out_ctr), 0);
        chk("rst_valid", int'(out_valid), 0);

        // Three garbage bits, then two commas on lane 0.
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b1, 4'($urandom));
        send_byte(8'h12, 8'h34, 8'h56, 8'hBC);
        chk("lock_after_1st", int'(out_lock), 0);
        send_byte(8'h78, 8'h9A, 8'hDE, 8'hBC);
        chk("lock_after_2nd", int'(out_lock), 1);
        chk("lock_ctr", int'(out_ctr), 0);
        chk("no_strobe_pre_lock", strobes, 0);

        // Data capture eight bits after lock.
        send_byte(8'hA5, 8'h3C, 8'hFF, 8'h01);
        chk("cap_valid", int'(out_valid), 1);
        chk("cap_lane3", int'(out3), 8'hA5);
        chk("cap_lane2", int'(out2), 8'h3C);
        chk("cap_lane1", int'(out1), 8'hFF);
        chk("cap_lane0", int'(out0), 8'h01);
        chk("cap_strobes", strobes, 1);

        // Five stall cycles mid-byte: same byte, strobe delayed.
        s0 = strobes;
        send_bits(8'h5A, 8'hC3, 8'h0F, 8'h00, 7, 5);
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b1, 4'($urandom));
        send_bits(8'h5A, 8'hC3, 8'h0F, 8'h00, 4, 1);
        chk("stall_no_early", strobes - s0, 0);
        send_bits(8'h5A, 8'hC3, 8'h0F, 8'h00, 0, 0);
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_lane3", int'(out3), 8'h5A);
        chk("stall_lane1", int'(out1), 8'h0F);

        // Stream loss mid-byte drops lock; outputs keep their last bytes.
        s0 = strobes;
        send_bits(8'h11, 8'h22, 8'h33, 8'h00, 7, 4);
        cycle(1'b1, 1'b1, 1'b0, 4'($urandom));
        chk("loss_lock", int'(out_lock), 0);
        chk("loss_hold", int'(out3), 8'h5A);
        send_bits(8'h11, 8'h22, 8'h33, 8'h00, 3, 0);
        chk("loss_no_strobe", strobes - s0, 0);
        chk("loss_still_hunting", int'(out_lock), 0);

        // Comma followed by a non-comma returns to hunting; two commas relock.
        send_byte(8'h00, 8'h00, 8'h00, 8'hBC);
        send_byte(8'h00, 8'h00, 8'h00, 8'h00);
        chk("fail_align_lock", int'(out_lock), 0);
        lock_up();
        chk("relock", int'(out_lock), 1);

        // Comma slot while locked: stripped or delivered depending on build.
        s0 = strobes;
        send_byte(8'hC1, 8'hB1, 8'hA1, 8'h55);
        send_byte(8'hC2, 8'hB2, 8'hA2, 8'hBC);
        send_byte(8'hC3, 8'hB3, 8'hA3, 8'h66);
        tgt = STRIP ? 2 : 3;
        chk("strip_strobes", strobes - s0, tgt);
        chk("strip_last_lane0", int'(out0), 8'h66);

        // Randomized traffic: comma-rich lane 0, stalls, slips, rare loss and one reset.
        for (int b = 0; b < 200; b++) begin
            rb[0] = ($urandom_range(0, 9) < 4) ? 8'hBC : 8'($urandom);
            for (int i = 1; i < 4; i++) rb[i] = 8'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++)
                    cycle(1'b1, 1'b1, 1'b1, 4'($urandom));
            end
            for (int k = 7; k >= 0; k--) begin
                while ($urandom_range(0, 9) == 0) cycle(1'b1, 1'b0, 1'b1, 4'($urandom));
                if ($urandom_range(0, 299) == 0) cycle(1'b1, 1'b1, 1'b0, 4'($urandom));
                if (b == 100 && k == 3) cycle(1'b0, 1'b1, 1'b1, 4'($urandom));
                cycle(1'b1, 1'b1, 1'b1, {rb[3][k], rb[2][k], rb[1][k], rb[0][k]});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
